// File: rtl/fir_mac_tdm.sv
// Time-multiplexed multi-channel FIR built around one signed MAC: shared runtime-loadable
// coefficients, per-channel circular sample histories, rounded and saturated output.
module fir_mac_tdm #(
   parameter int TAPS  = 128,
   parameter int CH    = 2,
   parameter int BW    = 16,
   parameter int CW    = 16,
   parameter int ACCW  = 40,
   parameter int SHIFT = 15,
   parameter int OW    = 16,
   localparam int AW   = $clog2(TAPS),
   localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic signed [BW-1:0]  din,
   input  logic [CHW-1:0]        din_ch,
   input  logic                  din_vld,
   output logic                  din_rdy,
   input  logic                  coef_we,
   input  logic [AW-1:0]         coef_addr,
   input  logic signed [CW-1:0]  coef_data,
   output logic                  coef_rdy,
   output logic signed [OW-1:0]  dout,
   output logic [CHW-1:0]        dout_ch,
   output logic                  dout_sat,
   output logic                  dout_vld,
   input  logic                  dout_rdy
);

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MAC, S_OUT} state_t;

   localparam logic [AW-1:0]      LAST = AW'(TAPS - 1);
   localparam logic [CHW:0]       CHL  = (CHW + 1)'(CH);
   localparam logic signed [ACCW:0] RND  =
      (SHIFT > 0) ? ((ACCW + 1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   localparam logic signed [ACCW:0] MAXV = {{(ACCW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
   localparam logic signed [ACCW:0] MINV = {{(ACCW + 2 - OW){1'b1}}, {(OW - 1){1'b0}}};
   localparam logic [OW-1:0]      OMAX = {1'b0, {(OW - 1){1'b1}}};
   localparam logic [OW-1:0]      OMIN = {1'b1, {(OW - 1){1'b0}}};

   // Round half up, then arithmetic shift; one extra bit keeps the rounding add from wrapping.
   function automatic logic signed [ACCW:0] round_shift(input logic signed [ACCW-1:0] a);
      logic signed [ACCW:0] t;
      t = {a[ACCW-1], a} + RND;
      return t >>> SHIFT;
   endfunction

   // Returns {saturated flag, clamped value}.
   function automatic logic [OW:0] saturate(input logic signed [ACCW:0] r);
      logic [OW:0] res;
      if (r > MAXV)      res = {1'b1, OMAX};
      else if (r < MINV) res = {1'b1, OMIN};
      else               res = {1'b0, r[OW-1:0]};
      return res;
   endfunction

   state_t                 r_state, w_state_nxt;
   logic [AW-1:0]          r_cnt;
   logic [AW-1:0]          r_base;
   logic [CHW-1:0]         r_ch;
   logic [AW-1:0]          r_wp [CH];
   logic signed [ACCW-1:0] r_acc;
   logic signed [CW-1:0]   r_coef [TAPS];
   logic signed [BW-1:0]   r_hist [CH][TAPS];

   logic                   w_ch_ok, w_accept;
   logic [AW-1:0]          w_rd_addr;
   logic signed [CW-1:0]   w_h;
   logic signed [BW-1:0]   w_x;
   logic signed [BW+CW-1:0] w_prod;
   logic signed [ACCW-1:0] w_acc_nxt;
   logic [OW:0]            w_res;

   assign w_ch_ok   = ({1'b0, din_ch} < CHL);
   assign w_accept  = (r_state == S_IDLE) && din_vld && w_ch_ok;
   assign w_rd_addr = r_base - r_cnt;
   assign w_h       = r_coef[r_cnt];
   assign w_x       = r_hist[r_ch][w_rd_addr];
   assign w_prod    = w_h * w_x;
   assign w_acc_nxt = r_acc + {{(ACCW - BW - CW){w_prod[BW+CW-1]}}, w_prod};
   assign w_res     = saturate(round_shift(w_acc_nxt));

   always_comb begin
      w_state_nxt = r_state;
      din_rdy     = 1'b0;
      coef_rdy    = 1'b0;
      case (r_state)
         S_CLEAR: if (r_cnt == LAST) w_state_nxt = S_IDLE;
         S_IDLE: begin
            din_rdy  = 1'b1;
            coef_rdy = 1'b1;
            if (w_accept) w_state_nxt = S_MAC;
         end
         S_MAC:   if (r_cnt == LAST) w_state_nxt = S_OUT;
         S_OUT:   if (dout_rdy) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_CLEAR;
         r_cnt    <= '0;
         r_base   <= '0;
         r_ch     <= '0;
         r_acc    <= '0;
         dout     <= '0;
         dout_ch  <= '0;
         dout_sat <= 1'b0;
         dout_vld <= 1'b0;
         for (int c = 0; c < CH; c++) r_wp[c] <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_CLEAR: r_cnt <= r_cnt + AW'(1);
            S_IDLE: begin
               if (w_accept) begin
                  r_ch         <= din_ch;
                  r_base       <= r_wp[din_ch];
                  r_wp[din_ch] <= r_wp[din_ch] + AW'(1);
                  r_acc        <= '0;
                  r_cnt        <= '0;
               end
            end
            S_MAC: begin
               r_acc <= w_acc_nxt;
               r_cnt <= r_cnt + AW'(1);
               if (r_cnt == LAST) begin
                  dout     <= w_res[OW-1:0];
                  dout_sat <= w_res[OW];
                  dout_ch  <= r_ch;
                  dout_vld <= 1'b1;
               end
            end
            S_OUT: if (dout_rdy) dout_vld <= 1'b0;
            default: ;
         endcase
      end
   end

   // Storage arrays carry no reset; histories are zeroed by the CLEAR sweep instead.
   always_ff @(posedge clk) begin
      if (coef_we && (r_state == S_IDLE)) r_coef[coef_addr] <= coef_data;
      if (r_state == S_CLEAR) begin
         for (int c = 0; c < CH; c++) r_hist[c][r_cnt] <= '0;
      end else if (w_accept) begin
         r_hist[din_ch][r_wp[din_ch]] <= din;
      end
   end

endmodule
